zjh_161_timer_ctrl: RTL and testbench
=====================================

Name: zjh_161_timer_ctrl

Overview:
- Sequencer for a chain of cascaded zjh_74HC161 4-bit counters (STAGES deep) used as a programmable interval timer.
- Latches a period, preloads the chain through its active-low PE/D inputs, enables counting via Cep/Cet, and watches the chain's final TC.
- On expiry it pulses Done and either stops (one-shot) or reloads with zero dead cycles (auto-reload).
- Sits between the system control logic and the counter datapath.

Parameters:
STAGES, 2, number of cascaded 4-bit counters; chain width W = 4*STAGES (default 8)

Ports:
Clk  input  1  system clock, rising edge
MR  input  1  master reset, asynchronous, active-high
Start  input  1  one-cycle request: latch Period and (re)start the timer
Stop  input  1  abort; return to IDLE
Mode  input  1  0 = one-shot, 1 = auto-reload; sampled with Start
Hold  input  1  pause counting while high (RUN only)
Period  input  W  interval N in cycles; 0 means 2^W
Cnt_TC  input  1  TC of most-significant counter stage (chain at all-ones with Cet high)
Cnt_PE  output  1  active-low parallel-load to every stage
Cnt_Cep  output  1  count enable P to every stage
Cnt_Cet  output  1  count enable T to least-significant stage
Cnt_D  output  W  preload value to chain
Busy  output  1  high in LOAD or RUN
Done  output  1  one-cycle expiry pulse
Exp_Cnt  output  8  saturating expiry count since last Start

Behaviour:
- Reset (MR=1, async): state IDLE, mode_r=0, per_r=0, Exp_Cnt=0, Done=0. Outputs follow the state decode: Cnt_PE=1, Cnt_Cep=0, Cnt_Cet=0, Cnt_D=0, Busy=0.
- Cnt_D = (~per_r + 1) mod 2^W, registered. Counting up from 2^W-N reaches all-ones after N cycles. N=0 gives preload 0, a period of 2^W.
- States and transitions (priority Stop > Start > expiry):
  - IDLE: Start -> latch per_r=Period, mode_r=Mode, clear Exp_Cnt, go to LOAD.
  - LOAD: Cnt_PE=0, Cep=Cet=0; chain loads Cnt_D at this edge. Next state RUN. Hold is ignored.
  - RUN: Cnt_PE=1, Cnt_Cet=1, Cnt_Cep=!Hold. Expiry is a cycle with Cnt_TC=1 and Hold=0.
    - Expiry, mode_r=1: Cnt_PE driven 0 combinationally in the same cycle, so the chain reloads at that edge. Stay in RUN.
    - Expiry, mode_r=0: go to IDLE. The chain wrapping to 0 at that edge is permitted.
  - Start in LOAD/RUN: relatch Period/Mode, clear Exp_Cnt, go to LOAD. Any in-progress expiry in that cycle is discarded and Done is not pulsed.
  - Stop in any state: go to IDLE next edge. Done is not pulsed. Exp_Cnt is kept.
- Cnt_PE/Cep/Cet are combinational from state, Hold, mode_r and Cnt_TC only. There is no loop, because Cet does not depend on Cnt_TC.
- Timing, Start sampled at edge 0:
  - LOAD during cycle 1; chain = 2^W-N after edge 1.
  - Expiry cycle N after load; Done high the cycle after the expiry edge.
  - Auto-reload repeats exactly every N cycles, with Hold cycles extending the period one-for-one.
- Hold while chain is all-ones: Cnt_TC may stay 1, but expiry is suppressed until Hold falls. No double expiry.
- Exp_Cnt increments on each expiry and saturates at 255.
- Done and Exp_Cnt are registered; Busy is decoded from the state.
- MR mid-operation returns to IDLE immediately and clears all registers. The counter chain's own reset is outside this block.

Test Plan:
- MR pulse, then idle -> Cnt_PE=1, Cep=Cet=0, Busy=0, Done=0, Exp_Cnt=0.
- Start with Period=5, Mode=0, chain model attached:
  - Cnt_D=0xFB, Cnt_PE=0 for exactly one cycle.
  - Done pulses once 6 cycles after the LOAD cycle ends.
  - Then IDLE, Exp_Cnt=1.
- Period=3, Mode=1, run 12 cycles:
  - Done every 3 cycles, no gaps; Cnt_PE low in each TC cycle.
  - Exp_Cnt=4 after four expiries.
- Period=4, Mode=1, Hold high for 2 cycles with chain at 0xFF -> no expiry while held; expiry on the first cycle Hold=0; that period is 6 cycles.
- Stop on the expiry cycle -> IDLE, no Done. Start and Stop in the same cycle -> IDLE.
- Period=0, Mode=0 -> Cnt_D=0x00, expiry after 256 counting cycles. Start during RUN -> returns to LOAD and Exp_Cnt clears.

Source files
------------

// File: rtl/zjh_161_timer_ctrl.sv
// Programmable interval timer sequencer driving a cascade of 74HC161-style counters.
// Preloads the chain with the two's complement of the period and watches the final TC.
module zjh_161_timer_ctrl #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned W      = 4 * STAGES
) (
  input  logic         Clk,
  input  logic         MR,
  input  logic         Start,
  input  logic         Stop,
  input  logic         Mode,
  input  logic         Hold,
  input  logic [W-1:0] Period,
  input  logic         Cnt_TC,
  output logic         Cnt_PE,
  output logic         Cnt_Cep,
  output logic         Cnt_Cet,
  output logic [W-1:0] Cnt_D,
  output logic         Busy,
  output logic         Done,
  output logic [7:0]   Exp_Cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state;
  logic   mode_r;
  logic   expiry;

  // Hold masks expiry so a chain parked at all-ones cannot expire twice.
  assign expiry = (state == RUN) && Cnt_TC && !Hold;

  always_comb begin
    Cnt_PE  = 1'b1;
    Cnt_Cep = 1'b0;
    Cnt_Cet = 1'b0;
    Busy    = 1'b0;
    case (state)
      LOAD: begin
        Cnt_PE = 1'b0;
        Busy   = 1'b1;
      end
      RUN: begin
        Cnt_Cet = 1'b1;
        Cnt_Cep = !Hold;
        Cnt_PE  = !(expiry && mode_r);
        Busy    = 1'b1;
      end
      default: ;
    endcase
  end

  // The preload is latched directly with Start, so it is already valid in LOAD.
  always_ff @(posedge Clk or posedge MR) begin
    if (MR) begin
      state   <= IDLE;
      mode_r  <= 1'b0;
      Cnt_D   <= '0;
      Exp_Cnt <= '0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (Stop) begin
        state <= IDLE;
      end else if (Start) begin
        state   <= LOAD;
        mode_r  <= Mode;
        Cnt_D   <= (~Period) + W'(1);
        Exp_Cnt <= '0;
      end else begin
        case (state)
          LOAD: state <= RUN;
          RUN: begin
            if (expiry) begin
              Done <= 1'b1;
              if (Exp_Cnt != 8'hFF) Exp_Cnt <= Exp_Cnt + 8'd1;
              if (!mode_r) state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zjh_161_timer_ctrl.sv
// Directed bench for zjh_161_timer_ctrl with a behavioural 8-bit counter chain attached.
module tb_zjh_161_timer_ctrl;

  logic       Clk = 1'b0;
  logic       MR = 1'b0;
  logic       Start = 1'b0;
  logic       Stop = 1'b0;
  logic       Mode = 1'b0;
  logic       Hold = 1'b0;
  logic [7:0] Period = '0;
  logic       Cnt_TC;
  logic       Cnt_PE;
  logic       Cnt_Cep;
  logic       Cnt_Cet;
  logic [7:0] Cnt_D;
  logic       Busy;
  logic       Done;
  logic [7:0] Exp_Cnt;

  logic       chain_rst = 1'b1;
  logic [7:0] chain;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  zjh_161_timer_ctrl #(.STAGES(2)) dut (
    .Clk     (Clk),
    .MR      (MR),
    .Start   (Start),
    .Stop    (Stop),
    .Mode    (Mode),
    .Hold    (Hold),
    .Period  (Period),
    .Cnt_TC  (Cnt_TC),
    .Cnt_PE  (Cnt_PE),
    .Cnt_Cep (Cnt_Cep),
    .Cnt_Cet (Cnt_Cet),
    .Cnt_D   (Cnt_D),
    .Busy    (Busy),
    .Done    (Done),
    .Exp_Cnt (Exp_Cnt)
  );

  always #5 Clk = ~Clk;

  // Cascaded counter chain: synchronous load has priority over counting.
  always_ff @(posedge Clk) begin
    if (chain_rst)           chain <= '0;
    else if (!Cnt_PE)        chain <= Cnt_D;
    else if (Cnt_Cep && Cnt_Cet) chain <= chain + 8'd1;
  end
  assign Cnt_TC = (chain == 8'hFF) && Cnt_Cet;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [11:0] pe_pat, done_pat;
    logic [9:0]  pe_pat2, done_pat2, cep_pat2;
    int unsigned done_cnt, done_at, pe_low, n;

    // Reset
    #1 MR = 1'b1;
    #10;
    check("rst_pe",   Cnt_PE,  1);
    check("rst_cep",  Cnt_Cep, 0);
    check("rst_cet",  Cnt_Cet, 0);
    check("rst_busy", Busy,    0);
    check("rst_done", Done,    0);
    check("rst_exp",  Exp_Cnt, 0);
    check("rst_d",    Cnt_D,   0);
    MR = 1'b0;
    tick();
    chain_rst = 1'b0;

    // One-shot, N=5
    Period = 8'd5; Mode = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    #1;
    check("os_load_pe",   Cnt_PE,  0);
    check("os_load_cep",  Cnt_Cep, 0);
    check("os_load_d",    Cnt_D,   8'hFB);
    check("os_load_busy", Busy,    1);
    tick();
    #1;
    check("os_run_pe",  Cnt_PE,  1);
    check("os_run_cep", Cnt_Cep, 1);
    check("os_run_cet", Cnt_Cet, 1);
    done_cnt = 0; done_at = 0; pe_low = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      #1;
      if (Done) begin done_cnt++; done_at = i; end
      if (!Cnt_PE) pe_low++;
    end
    check("os_done_cnt", done_cnt, 1);
    check("os_done_at",  done_at,  5);
    check("os_pe_low",   pe_low,   0);
    check("os_busy",     Busy,     0);
    check("os_exp",      Exp_Cnt,  1);

    // Auto-reload, N=3
    Period = 8'd3; Mode = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    #1;
    check("ar_load_d", Cnt_D, 8'hFD);
    tick();
    for (int i = 0; i < 12; i++) begin
      #1;
      pe_pat[i]   = ~Cnt_PE;
      done_pat[i] = Done;
      tick();
    end
    #1;
    check("ar_pe_pat",   pe_pat,   12'h924);
    check("ar_done_pat", done_pat, 12'h248);
    check("ar_done_end", Done,     1);
    check("ar_exp",      Exp_Cnt,  4);

    // Restart during RUN with N=4, then Hold over the all-ones cycle
    Period = 8'd4; Mode = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    #1;
    check("rs_pe",   Cnt_PE,  0);
    check("rs_d",    Cnt_D,   8'hFC);
    check("rs_exp",  Exp_Cnt, 0);
    check("rs_done", Done,    0);
    check("rs_busy", Busy,    1);
    tick();
    for (int j = 0; j < 10; j++) begin
      Hold = (j == 3 || j == 4);
      #1;
      pe_pat2[j]   = ~Cnt_PE;
      done_pat2[j] = Done;
      cep_pat2[j]  = Cnt_Cep;
      tick();
    end
    Hold = 1'b0;
    #1;
    check("hd_pe_pat",   pe_pat2,   10'h220);
    check("hd_done_pat", done_pat2, 10'h040);
    check("hd_cep_pat",  cep_pat2,  10'h3E7);
    check("hd_done_end", Done,      1);
    check("hd_exp",      Exp_Cnt,   2);

    // Stop on the expiry cycle
    tick(); tick(); tick();
    Stop = 1'b1;
    #1;
    check("sp_pe_exp", Cnt_PE, 0);
    tick();
    Stop = 1'b0;
    #1;
    check("sp_busy", Busy,    0);
    check("sp_done", Done,    0);
    check("sp_exp",  Exp_Cnt, 2);

    // Start and Stop together
    Period = 8'd7; Start = 1'b1; Stop = 1'b1;
    tick();
    Start = 1'b0; Stop = 1'b0;
    #1;
    check("ss_busy", Busy,  0);
    check("ss_d",    Cnt_D, 8'hFC);

    // Period 0 means 256 cycles
    Period = 8'd0; Mode = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    #1;
    check("p0_d",   Cnt_D,   8'h00);
    check("p0_exp", Exp_Cnt, 0);
    check("p0_pe",  Cnt_PE,  0);
    tick();
    n = 0;
    while (!Done && n < 300) begin
      tick();
      n++;
    end
    check("p0_len",  n,       256);
    check("p0_busy", Busy,    0);
    check("p0_cnt",  Exp_Cnt, 1);

    // N=1 auto-reload expires every cycle; Exp_Cnt saturates
    Period = 8'd1; Mode = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    repeat (300) tick();
    #1;
    check("sat_exp",  Exp_Cnt, 8'hFF);
    check("sat_done", Done,    1);
    check("sat_pe",   Cnt_PE,  0);
    check("sat_busy", Busy,    1);

    // Asynchronous reset mid-run
    MR = 1'b1;
    #1;
    check("mr_busy", Busy,    0);
    check("mr_exp",  Exp_Cnt, 0);
    check("mr_done", Done,    0);
    check("mr_d",    Cnt_D,   0);
    check("mr_pe",   Cnt_PE,  1);
    check("mr_cet",  Cnt_Cet, 0);
    MR = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
